// File: rtl/date_seq.sv
// date_seq: registered calendar date sequencer (day/month/year).
// Steps the date one day per advance pulse. Loads are range-checked, so
// every date that reaches the outputs is a legal date of the chosen calendar.
module date_seq #(
    parameter int CALENDAR    = 0,
    parameter int RESET_DAY   = 1,
    parameter int RESET_MONTH = 1,
    parameter int RESET_YEAR  = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [5:0]  load_day,
    input  logic [3:0]  load_month,
    input  logic [10:0] load_year,
    output logic [5:0]  dayOfMonth,
    output logic [3:0]  month,
    output logic [10:0] year,
    output logic        stepped,
    output logic        load_err,
    output logic        year_wrap
);

    // Only the two supported calendars may be built.
    if (CALENDAR != 0 && CALENDAR != 1) begin : g_badCalendar
        $error("date_seq: CALENDAR must be 0 (Gregorian) or 1 (Symmetry454)");
    end

    logic [5:0]  day_q,      day_d;
    logic [3:0]  month_q,    month_d;
    logic [10:0] year_q,     year_d;
    logic        stepped_q,  stepped_d;
    logic        loadErr_q,  loadErr_d;
    logic        yearWrap_q, yearWrap_d;

    logic [5:0]  curLen;
    logic [5:0]  loadLen;
    logic        loadLegal;

    // The Symmetry454 product 52*Y+146 peaks at 106590, so it needs 17 bits.
    function automatic logic isLeap(input logic [10:0] y);
        logic [16:0] prod;
        prod = 17'(y) * 17'd52 + 17'd146;
        if (CALENDAR == 1) begin
            return (prod % 17'd293) < 17'd52;
        end
        return ((y[1:0] == 2'b00) && ((y % 11'd100) != 11'd0)) || ((y % 11'd400) == 11'd0);
    endfunction

    // Months outside 1..12 report length 0 so a load with them always fails.
    function automatic logic [5:0] monthLen(input logic [3:0] m, input logic [10:0] y);
        logic leap;
        leap = isLeap(y);
        if (m == 4'd0 || m > 4'd12) begin
            return 6'd0;
        end
        if (CALENDAR == 1) begin
            case (m)
                4'd2, 4'd5, 4'd8, 4'd11: return 6'd35;
                4'd12:                   return leap ? 6'd35 : 6'd28;
                default:                 return 6'd28;
            endcase
        end
        case (m)
            4'd2:                    return leap ? 6'd29 : 6'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 6'd30;
            default:                 return 6'd31;
        endcase
    endfunction

    assign curLen    = monthLen(month_q, year_q);
    assign loadLen   = monthLen(load_month, load_year);
    assign loadLegal = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                       (load_day >= 6'd1) && (load_day <= loadLen);

    // Next date and pulses; load has priority over advance, even when rejected.
    always_comb begin
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        stepped_d  = 1'b0;
        loadErr_d  = 1'b0;
        yearWrap_d = 1'b0;
        if (load) begin
            if (loadLegal) begin
                day_d     = load_day;
                month_d   = load_month;
                year_d    = load_year;
                stepped_d = 1'b1;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (advance) begin
            stepped_d = 1'b1;
            if (day_q < curLen) begin
                day_d = day_q + 6'd1;
            end else if (month_q < 4'd12) begin
                day_d   = 6'd1;
                month_d = month_q + 4'd1;
            end else if (year_q < 11'd2047) begin
                day_d   = 6'd1;
                month_d = 4'd1;
                year_d  = year_q + 11'd1;
            end else begin
                day_d      = 6'd1;
                month_d    = 4'd1;
                year_d     = 11'd0;
                yearWrap_d = 1'b1;
            end
        end
    end

    // Date and pulse registers; reset drops any pending action immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q      <= 6'(RESET_DAY);
            month_q    <= 4'(RESET_MONTH);
            year_q     <= 11'(RESET_YEAR);
            stepped_q  <= 1'b0;
            loadErr_q  <= 1'b0;
            yearWrap_q <= 1'b0;
        end else begin
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            stepped_q  <= stepped_d;
            loadErr_q  <= loadErr_d;
            yearWrap_q <= yearWrap_d;
        end
    end

    assign dayOfMonth = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign stepped    = stepped_q;
    assign load_err   = loadErr_q;
    assign year_wrap  = yearWrap_q;

endmodule
